// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master data-RAM arbiter: owner encoding,
// pipeline state type and default geometry.
package ram_arbiter_pkg;

   localparam int ADDR_W_DEF   = 10;
   localparam int DATA_W_DEF   = 32;
   localparam int HOLD_MAX_DEF = 4;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_M0   = 2'd1;
   localparam logic [1:0] OWN_M1   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = OWN_NONE,
      ST_M0   = OWN_M0,
      ST_M1   = OWN_M1
   } own_state_e;

endpackage

// File: rtl/ram_arbiter_rr_grant.sv
// Combinational two-way grant with a saturating streak counter that forces
// master 1 in after HOLD_MAX consecutive master-0 wins under contention.
module ram_arbiter_rr_grant
   import ram_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic m0_req,
   input  logic m1_req,
   output logic m0_gnt,
   output logic m1_gnt
);

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   logic [3:0] streak_q;
   logic [3:0] streak_d;
   logic       m1_turn_s;

   // Grant selection and next streak value.
   always_comb begin
      m1_turn_s = (streak_q == HOLD_LIM);
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      if (!rst_n) begin
         m0_gnt = 1'b0;
         m1_gnt = 1'b0;
      end else if (m0_req && m1_req) begin
         m0_gnt = !m1_turn_s;
         m1_gnt = m1_turn_s;
      end else begin
         m0_gnt = m0_req;
         m1_gnt = m1_req;
      end

      streak_d = streak_q;
      if (m1_gnt || !m1_req) begin
         streak_d = 4'd0;
      end else if (m0_gnt && (streak_q != HOLD_LIM)) begin
         streak_d = streak_q + 4'd1;
      end else begin
         streak_d = streak_q;
      end
   end

   // Streak register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q <= 4'd0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between a priority CPU master and a DMA
// master; registered RAM command, read data returned two cycles after grant.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic              clk,
   input  logic              RSTN,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   own_state_e        state_q,     state_d;
   logic              iss_rd_q,    iss_rd_d;
   logic              ram_we_q,    ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
   logic [DATA_W-1:0] ram_din_q,   ram_din_d;
   logic              m0_rvalid_q, m0_rvalid_d;
   logic              m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0] m0_rdata_q,  m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q,  m1_rdata_d;
   logic              busy_q,      busy_d;

   ram_arbiter_rr_grant #(
      .HOLD_MAX (HOLD_MAX)
   ) u_grant (
      .clk    (clk),
      .rst_n  (RSTN),
      .m0_req (m0_req),
      .m1_req (m1_req),
      .m0_gnt (m0_gnt),
      .m1_gnt (m1_gnt)
   );

   // Issue-stage command mux and return-stage tagging.
   always_comb begin
      state_d    = ST_IDLE;
      iss_rd_d   = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      if (m0_gnt) begin
         state_d    = ST_M0;
         iss_rd_d   = !m0_we;
         ram_we_d   = m0_we;
         ram_addr_d = m0_addr;
         ram_din_d  = m0_wdata;
      end else if (m1_gnt) begin
         state_d    = ST_M1;
         iss_rd_d   = !m1_we;
         ram_we_d   = m1_we;
         ram_addr_d = m1_addr;
         ram_din_d  = m1_wdata;
      end else begin
         state_d    = ST_IDLE;
         iss_rd_d   = 1'b0;
      end

      // The issue-stage owner tag becomes the return-stage rvalid.
      m0_rvalid_d = iss_rd_q && (state_q == ST_M0);
      m1_rvalid_d = iss_rd_q && (state_q == ST_M1);
      m0_rdata_d  = m0_rvalid_q ? ram_dout : m0_rdata_q;
      m1_rdata_d  = m1_rvalid_q ? ram_dout : m1_rdata_q;
      busy_d      = iss_rd_d || m0_rvalid_d || m1_rvalid_d;
   end

   // Pipeline, owner state and output registers.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= ST_IDLE;
         iss_rd_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= {ADDR_W{1'b0}};
         ram_din_q   <= {DATA_W{1'b0}};
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= {DATA_W{1'b0}};
         m1_rdata_q  <= {DATA_W{1'b0}};
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         iss_rd_q    <= iss_rd_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign busy      = busy_q;
   // Read data is live from the RAM during the rvalid cycle, held afterwards.
   assign m0_rdata  = m0_rvalid_q ? ram_dout : m0_rdata_q;
   assign m1_rdata  = m1_rvalid_q ? ram_dout : m1_rdata_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter that shares the single-port data RAM between master 0 (CPU-side bus, high priority) and master 1 (DMA/debug port, e.g. a VGA frame reader or memory dumper).
- Sits between the bus RAM port and the data RAM.
- Performs request/grant arbitration with a bounded-starvation guarantee.
- Issues registered RAM commands and returns read data, tagged to the correct master, with fixed latency.

Parameters:
ADDR_W, 10, RAM word-address width
DATA_W, 32, data width
HOLD_MAX, 4, max consecutive m0 grants while m1 is waiting before m1 is forced in (range 1..15)

Ports:
clk  in  1  single clock, rising edge
RSTN  in  1  asynchronous reset, active-low
m0_req  in  1  master 0 request, held until granted
m0_we  in  1  master 0 write (1) / read (0)
m0_addr  in  ADDR_W  master 0 word address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 granted this cycle (combinational)
m0_rvalid  out  1  master 0 read data valid
m0_rdata  out  DATA_W  master 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_* for master 1
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_din  out  DATA_W  RAM write data (registered)
ram_dout  in  DATA_W  RAM read data, valid 1 cycle after the address is presented
busy  out  1  a read is in flight (issue or return stage)

Behaviour:
- Reset (RSTN=0, async): ram_we=0, ram_addr=0, ram_din=0, m0_rvalid=m1_rvalid=0, busy=0, streak=0, state=IDLE. Gnt outputs are forced 0 while RSTN=0.
- Grant rule, cycle N, evaluated combinationally from req and state. At most one gnt per cycle.
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both requesting: grant m0 unless streak==HOLD_MAX, in which case grant m1.
  - Neither: no grant.
- Requester handshake: a request is consumed on a cycle where req&&gnt. The master changes or drops req only after gnt; addr/we/wdata must be stable while req is high.
- Streak counter (4 bit):
  - Increments on each m0 grant while m1_req=1.
  - Clears on any m1 grant, or on any cycle where m1_req=0.
  - Saturates at HOLD_MAX.
- State machine: IDLE / M0 / M1. Records the owner of the command issued this cycle. Next state = granted master, or IDLE if no grant. Used for the rvalid tag and the busy flag.
- Issue stage, N+1: ram_we/ram_addr/ram_din are registered from the granted master. If no grant, ram_we=0 and addr/din hold their previous values.
- Return stage, N+2 (reads only):
  - The owning mX_rvalid pulses for 1 cycle.
  - mX_rdata = ram_dout, passed through combinationally while rvalid=1; otherwise holds the last captured value.
- Writes produce no rvalid. Write-then-read to the same address on back-to-back grants returns the new data, because RAM writes commit at the N+1 edge.
- Throughput: 1 command per cycle. Back-to-back reads from alternating masters return in grant order.
- busy=1 whenever the issue or return stage holds a read.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced. Masters must re-request after reset.
- Boundary conditions:
  - Simultaneous requests at streak saturation: m1 wins.
  - HOLD_MAX=1 gives strict alternation under contention.
  - Address wrap is not handled: addresses are passed through unchanged.

Decomposition:
- Shared package (header include): owner encoding constants OWN_NONE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2; default widths ADDR_W/DATA_W.
- One natural sub-module: rr_grant, the combinational grant logic plus the streak counter.
- The pipeline and tag registers stay in ram_arbiter.

Test Plan:
- Reset then idle: RSTN low for 3 cycles, release → all outputs 0, no gnt, ram_we=0 for 10 cycles.
- m0 write 0xDEADBEEF @0x005, then m0 read @0x005 → m0_gnt both cycles; ram_we=1 at N+1; m0_rvalid at N+3 with m0_rdata=0xDEADBEEF; m1_rvalid never asserted.
- Contention, HOLD_MAX=4: m0_req and m1_req both held high with reads → grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1…; every rvalid is tagged to the correct master with the correct RAM data.
- m1 alone: m1 reads @0x3FF preloaded with 0x12345678 → m1_gnt same cycle, m1_rvalid 2 cycles later, rdata=0x12345678, busy high exactly for cycles N+1..N+2.
- Reset mid-read: assert RSTN low in cycle N+1 of an m0 read → no m0_rvalid; ram_we=0; streak cleared, so a subsequent contended grant goes to m0.
- Alternating single-cycle requests from both masters with interleaved writes/reads to the same address → read-after-write ordering preserved; no dropped or duplicated rvalid (scoreboard count of rvalids equals count of granted reads).
